// File: rtl/matmul_serial_pkg.sv
// Shared types and helpers for the serial-I/O matrix multiplier.
package matmul_serial_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_COMPUTE,
    ST_SEND
  } state_e;

  function automatic int unsigned acc_width(input int unsigned n, input int unsigned dw);
    return 2 * dw + $clog2(n);
  endfunction

  // Zero- or sign-extend the low w bits of v to 64 bits.
  function automatic logic [63:0] extend(input logic [63:0] v, input int unsigned w,
                                         input logic sgn);
    logic [63:0] mask;
    logic        msb;
    mask = (64'(1) << w) - 64'(1);
    msb  = |(v & (64'(1) << (w - 1)));
    return (v & mask) | ((sgn && msb) ? ~mask : 64'(0));
  endfunction

endpackage

// File: rtl/serial_frame_rx.sv
// One 3-wire input link: synchroniser, bit/element framing, abort detect,
// and a shadow buffer that is promoted to the working buffer when not held.
module serial_frame_rx #(
  parameter int unsigned ELEMS = 16,
  parameter int unsigned W     = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               serial_data,
  input  logic               serial_clk,
  input  logic               frame_sync,
  input  logic               hold,
  input  logic               clr_valid,
  output logic               valid,
  output logic               abort,
  output logic [ELEMS*W-1:0] frame
);
  localparam int unsigned EW = $clog2(ELEMS);
  localparam int unsigned BW = $clog2(W);

  logic [2:0]         sync1_q, sync1_d, sync2_q, sync2_d;
  logic               prev_q, prev_d, stb_q, stb_d, sbit_q, sbit_d, sfs_q, sfs_d;
  logic [W-1:0]       shift_q, shift_d;
  logic [BW-1:0]      bcnt_q, bcnt_d;
  logic [EW-1:0]      ecnt_q, ecnt_d;
  logic               inf_q, inf_d, pend_q, pend_d, valid_q, valid_d, abort_q, abort_d;
  logic [ELEMS*W-1:0] shadow_q, shadow_d, work_q, work_d;

  always_comb begin
    sync1_d  = {frame_sync, serial_data, serial_clk};
    sync2_d  = sync1_q;
    prev_d   = sync2_q[0];
    stb_d    = sync2_q[0] & ~prev_q;
    sbit_d   = sync2_q[1];
    sfs_d    = sync2_q[2];
    shift_d  = shift_q;
    bcnt_d   = bcnt_q;
    ecnt_d   = ecnt_q;
    inf_d    = inf_q;
    pend_d   = pend_q;
    valid_d  = valid_q;
    abort_d  = 1'b0;
    shadow_d = shadow_q;
    work_d   = work_q;

    if (clr_valid) valid_d = 1'b0;
    if (pend_q && !hold) begin
      work_d  = shadow_q;
      valid_d = 1'b1;
      pend_d  = 1'b0;
    end

    // frame_sync always restarts at bit 0; seen inside a frame it is an abort
    if (stb_q) begin
      if (sfs_q) begin
        abort_d = inf_q;
        inf_d   = 1'b1;
        shift_d = W'(sbit_q);
        bcnt_d  = BW'(1);
        ecnt_d  = '0;
      end else if (inf_q) begin
        shift_d = {shift_q[W-2:0], sbit_q};
        if (bcnt_q == BW'(W - 1)) begin
          bcnt_d = '0;
          shadow_d[ecnt_q * W +: W] = shift_d;
          if (ecnt_q == EW'(ELEMS - 1)) begin
            inf_d  = 1'b0;
            pend_d = 1'b1;
          end else begin
            ecnt_d = ecnt_q + EW'(1);
          end
        end else begin
          bcnt_d = bcnt_q + BW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      prev_q   <= 1'b0;
      stb_q    <= 1'b0;
      sbit_q   <= 1'b0;
      sfs_q    <= 1'b0;
      shift_q  <= '0;
      bcnt_q   <= '0;
      ecnt_q   <= '0;
      inf_q    <= 1'b0;
      pend_q   <= 1'b0;
      valid_q  <= 1'b0;
      abort_q  <= 1'b0;
      shadow_q <= '0;
      work_q   <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      prev_q   <= prev_d;
      stb_q    <= stb_d;
      sbit_q   <= sbit_d;
      sfs_q    <= sfs_d;
      shift_q  <= shift_d;
      bcnt_q   <= bcnt_d;
      ecnt_q   <= ecnt_d;
      inf_q    <= inf_d;
      pend_q   <= pend_d;
      valid_q  <= valid_d;
      abort_q  <= abort_d;
      shadow_q <= shadow_d;
      work_q   <= work_d;
    end
  end

  assign valid = valid_q;
  assign abort = abort_q;
  assign frame = work_q;

endmodule

// File: rtl/matmul_serial_io_n.sv
// N x N serial-I/O matrix multiplier: two framed input links, one MAC
// iterating i/j/k, and a serializer returning C (row-major, MSB-first).
module matmul_serial_io_n
  import matmul_serial_pkg::*;
#(
  parameter int unsigned N      = 4,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ACC_W  = acc_width(N, DATA_W)
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic signed_mode,
  input  logic accum,
  input  logic A_in_serial_data,
  input  logic A_in_serial_clk,
  input  logic A_in_frame_sync,
  input  logic B_in_serial_data,
  input  logic B_in_serial_clk,
  input  logic B_in_frame_sync,
  output logic C_out_serial_data,
  output logic C_out_serial_clk,
  output logic C_out_frame_sync,
  output logic busy,
  output logic frame_err,
  output logic done
);
  localparam int unsigned NN  = N * N;
  localparam int unsigned IW  = $clog2(N);
  localparam int unsigned EW  = $clog2(NN);
  localparam int unsigned PW  = $clog2(ACC_W);
  localparam int unsigned CW  = NN * ACC_W;
  localparam int unsigned CIW = $clog2(CW);

  state_e              state_q, state_d;
  logic                sign_q, sign_d, acc_q, acc_d, busy_q, busy_d, done_q, done_d;
  logic                ferr_q, ferr_d;
  logic [IW-1:0]       i_q, i_d, j_q, j_d, k_q, k_d;
  logic [CW-1:0]       c_q, c_d;
  logic                sclk_q, sclk_d, sdat_q, sdat_d, sfs_q, sfs_d;
  logic                first_q, first_d, fin_q, fin_d;
  logic [EW-1:0]       oe_q, oe_d;
  logic [PW-1:0]       op_q, op_d;
  logic                hold_c, clr_valid_c, last_bit_c;
  logic                a_valid, b_valid, a_abort, b_abort;
  logic [NN*DATA_W-1:0] a_frame, b_frame;
  logic [DATA_W-1:0]   a_el_c, b_el_c;
  logic [ACC_W-1:0]    prod_c;
  logic [CIW-1:0]      nidx_c;

  assign hold_c = (state_q == ST_COMPUTE) || (state_q == ST_SEND);

  serial_frame_rx #(.ELEMS(NN), .W(DATA_W)) u_rx_a (
    .clk(clk), .rst(rst), .serial_data(A_in_serial_data), .serial_clk(A_in_serial_clk),
    .frame_sync(A_in_frame_sync), .hold(hold_c), .clr_valid(clr_valid_c),
    .valid(a_valid), .abort(a_abort), .frame(a_frame)
  );

  serial_frame_rx #(.ELEMS(NN), .W(DATA_W)) u_rx_b (
    .clk(clk), .rst(rst), .serial_data(B_in_serial_data), .serial_clk(B_in_serial_clk),
    .frame_sync(B_in_frame_sync), .hold(hold_c), .clr_valid(clr_valid_c),
    .valid(b_valid), .abort(b_abort), .frame(b_frame)
  );

  always_comb begin
    state_d     = state_q;
    sign_d      = sign_q;
    acc_d       = acc_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    ferr_d      = ferr_q;
    i_d         = i_q;
    j_d         = j_q;
    k_d         = k_q;
    c_d         = c_q;
    sclk_d      = sclk_q;
    sdat_d      = sdat_q;
    sfs_d       = sfs_q;
    first_d     = first_q;
    fin_d       = fin_q;
    oe_d        = oe_q;
    op_d        = op_q;
    clr_valid_c = 1'b0;
    a_el_c      = a_frame[(i_q * N + k_q) * DATA_W +: DATA_W];
    b_el_c      = b_frame[(k_q * N + j_q) * DATA_W +: DATA_W];
    prod_c      = ACC_W'(extend(64'(a_el_c), DATA_W, sign_q)) *
                  ACC_W'(extend(64'(b_el_c), DATA_W, sign_q));
    last_bit_c  = (op_q == '0) && (oe_q == EW'(NN - 1));
    nidx_c      = (op_q == '0) ? CIW'((oe_q + 1) * ACC_W + ACC_W - 1)
                               : CIW'(oe_q * ACC_W + op_q - 1);

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_WAIT;
          sign_d  = signed_mode;
          acc_d   = accum;
          busy_d  = 1'b1;
          ferr_d  = 1'b0;
        end
      end
      ST_WAIT: begin
        if (a_valid && b_valid) begin
          clr_valid_c = 1'b1;
          if (!acc_q) c_d = '0;
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
          state_d = ST_COMPUTE;
        end
      end
      ST_COMPUTE: begin
        c_d[(i_q * N + j_q) * ACC_W +: ACC_W] = c_q[(i_q * N + j_q) * ACC_W +: ACC_W] + prod_c;
        k_d = k_q + IW'(1);
        if (k_q == IW'(N - 1)) begin
          k_d = '0;
          j_d = j_q + IW'(1);
          if (j_q == IW'(N - 1)) begin
            j_d = '0;
            i_d = i_q + IW'(1);
            if (i_q == IW'(N - 1)) begin
              i_d     = '0;
              state_d = ST_SEND;
              first_d = 1'b1;
              oe_d    = '0;
              op_d    = PW'(ACC_W - 1);
            end
          end
        end
      end
      ST_SEND: begin
        // one load cycle, then alternate rise/fall; data advances on the fall
        if (first_q) begin
          first_d = 1'b0;
          sdat_d  = c_q[ACC_W-1];
          sfs_d   = 1'b1;
        end else if (fin_q) begin
          fin_d   = 1'b0;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else if (!sclk_q) begin
          sclk_d = 1'b1;
        end else begin
          sclk_d = 1'b0;
          sfs_d  = 1'b0;
          if (last_bit_c) begin
            sdat_d = 1'b0;
            fin_d  = 1'b1;
          end else begin
            sdat_d = c_q[nidx_c];
            if (op_q == '0) begin
              oe_d = oe_q + EW'(1);
              op_d = PW'(ACC_W - 1);
            end else begin
              op_d = op_q - PW'(1);
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (a_abort || b_abort) ferr_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sign_q  <= 1'b0;
      acc_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      c_q     <= '0;
      sclk_q  <= 1'b0;
      sdat_q  <= 1'b0;
      sfs_q   <= 1'b0;
      first_q <= 1'b0;
      fin_q   <= 1'b0;
      oe_q    <= '0;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      sign_q  <= sign_d;
      acc_q   <= acc_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
      c_q     <= c_d;
      sclk_q  <= sclk_d;
      sdat_q  <= sdat_d;
      sfs_q   <= sfs_d;
      first_q <= first_d;
      fin_q   <= fin_d;
      oe_q    <= oe_d;
      op_q    <= op_d;
    end
  end

  assign C_out_serial_data = sdat_q;
  assign C_out_serial_clk  = sclk_q;
  assign C_out_frame_sync  = sfs_q;
  assign busy              = busy_q;
  assign frame_err         = ferr_q;
  assign done              = done_q;

endmodule

// File: tb/tb_matmul_serial_io_n.sv
// Directed bench for matmul_serial_io_n at N=4, DATA_W=8 (ACC_W=18).
module tb_matmul_serial_io_n;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int AW = 18;
  localparam int NN = N * N;
  localparam int FB = NN * DW;
  localparam int CB = NN * AW;

  logic clk = 1'b0;
  logic rst, start, signed_mode, accum;
  logic a_d, a_c, a_f, b_d, b_c, b_f;
  logic c_d, c_c, c_f, busy, frame_err, done;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  matmul_serial_io_n #(.N(N), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .signed_mode(signed_mode), .accum(accum),
    .A_in_serial_data(a_d), .A_in_serial_clk(a_c), .A_in_frame_sync(a_f),
    .B_in_serial_data(b_d), .B_in_serial_clk(b_c), .B_in_frame_sync(b_f),
    .C_out_serial_data(c_d), .C_out_serial_clk(c_c), .C_out_frame_sync(c_f),
    .busy(busy), .frame_err(frame_err), .done(done)
  );

  function automatic logic [FB-1:0] ident_frame();
    logic [FB-1:0] f;
    f = '0;
    for (int e = 0; e < NN; e++) f[e*DW +: DW] = (e / N == e % N) ? 8'd1 : 8'd0;
    return f;
  endfunction

  // B[i][j] = 4i+j, i.e. element e holds e
  function automatic logic [FB-1:0] ramp_frame();
    logic [FB-1:0] f;
    for (int e = 0; e < NN; e++) f[e*DW +: DW] = 8'(e);
    return f;
  endfunction

  function automatic logic [FB-1:0] fill_frame(input logic [DW-1:0] v);
    logic [FB-1:0] f;
    for (int e = 0; e < NN; e++) f[e*DW +: DW] = v;
    return f;
  endfunction

  task automatic set_link(input bit sel_b, input logic d, input logic f, input logic c);
    if (sel_b) begin b_d = d; b_f = f; b_c = c; end
    else begin a_d = d; a_f = f; a_c = c; end
  endtask

  // Serial clock at clk/4; data/sync change while the serial clock is low.
  task automatic drive_link(input bit sel_b, input logic [FB-1:0] fr, input int nbits);
    logic bv;
    for (int b = 0; b < nbits; b++) begin
      bv = fr[(b / DW) * DW + DW - 1 - b % DW];
      set_link(sel_b, bv, b == 0, 1'b0);
      repeat (2) @(negedge clk);
      set_link(sel_b, bv, b == 0, 1'b1);
      repeat (2) @(negedge clk);
    end
    set_link(sel_b, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
  endtask

  task automatic pulse_start(input logic sm, input logic ac);
    signed_mode = sm;
    accum = ac;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Capture C bits on output-clock rising edges; stop_bit>0 returns early.
  task automatic collect(input int stop_bit, output logic [CB-1:0] cv, output int ndone,
                         output int busy_low, output int fs_bad, output int first_rise,
                         output bit to);
    int n;
    int tail;
    logic prev;
    cv = '0; ndone = 0; busy_low = 0; fs_bad = 0; first_rise = -1; to = 1'b1;
    n = 0; tail = 0; prev = c_c;
    for (int cyc = 1; cyc <= 6000; cyc++) begin
      @(negedge clk);
      if (done) ndone++;
      else if (ndone == 0 && !busy) busy_low++;
      if (!prev && c_c) begin
        if (first_rise < 0) first_rise = cyc;
        if (n < CB) cv[(n / AW) * AW + AW - 1 - n % AW] = c_d;
        if (c_f !== (n == 0)) fs_bad++;
        n++;
      end
      prev = c_c;
      if (stop_bit > 0 && n >= stop_bit) begin to = 1'b0; break; end
      if (ndone > 0) begin
        tail++;
        if (tail > 8) begin to = 1'b0; break; end
      end
    end
  endtask

  task automatic run_mm(input logic [FB-1:0] fa, input logic [FB-1:0] fb, input logic sm,
                        input logic ac, output logic [CB-1:0] cv, output int ndone,
                        output int busy_low, output int fs_bad, output bit to);
    int fr;
    drive_link(1'b0, fa, FB);
    drive_link(1'b1, fb, FB);
    pulse_start(sm, ac);
    collect(0, cv, ndone, busy_low, fs_bad, fr, to);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if ({c_d, c_c, c_f} !== 3'b000) begin failures++;
      $display("FAIL reset_link: got %b want 000", {c_d, c_c, c_f}); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (frame_err !== 1'b0) begin failures++;
      $display("FAIL reset_frame_err: got %b want 0", frame_err); end
  endtask

  task automatic test_unsigned();
    logic [CB-1:0] cv;
    int nd, bl, fsb;
    bit to;
    run_mm(ident_frame(), ramp_frame(), 1'b0, 1'b0, cv, nd, bl, fsb, to);
    checks++; if (to) begin failures++; $display("FAIL unsigned_timeout: got 1 want 0"); end
    for (int e = 0; e < NN; e++) begin
      checks++;
      if (cv[e*AW +: AW] !== 18'(e)) begin failures++;
        $display("FAIL unsigned_c[%0d]: got %0h want %0h", e, cv[e*AW +: AW], e); end
    end
    checks++; if (nd != 1) begin failures++; $display("FAIL unsigned_done_count: got %0d want 1", nd); end
    checks++; if (bl != 0) begin failures++; $display("FAIL unsigned_busy_gap: got %0d want 0", bl); end
    checks++; if (fsb != 0) begin failures++; $display("FAIL unsigned_frame_sync: got %0d bad want 0", fsb); end
  endtask

  task automatic test_signed();
    logic [CB-1:0] cv;
    int nd, bl, fsb;
    bit to;
    run_mm(fill_frame(8'hFF), fill_frame(8'h02), 1'b1, 1'b0, cv, nd, bl, fsb, to);
    for (int e = 0; e < NN; e++) begin
      checks++;
      if (cv[e*AW +: AW] !== 18'h3FFF8) begin failures++;
        $display("FAIL signed_c[%0d]: got %0h want 3fff8", e, cv[e*AW +: AW]); end
    end
    run_mm(fill_frame(8'hFF), fill_frame(8'h02), 1'b0, 1'b0, cv, nd, bl, fsb, to);
    for (int e = 0; e < NN; e++) begin
      checks++;
      if (cv[e*AW +: AW] !== 18'd2040) begin failures++;
        $display("FAIL zext_c[%0d]: got %0d want 2040", e, cv[e*AW +: AW]); end
    end
  endtask

  task automatic test_accum();
    logic [CB-1:0] cv;
    int nd, bl, fsb;
    bit to;
    run_mm(ident_frame(), ramp_frame(), 1'b0, 1'b0, cv, nd, bl, fsb, to);
    run_mm(ident_frame(), ramp_frame(), 1'b0, 1'b1, cv, nd, bl, fsb, to);
    for (int e = 0; e < NN; e++) begin
      checks++;
      if (cv[e*AW +: AW] !== 18'(2 * e)) begin failures++;
        $display("FAIL accum_c[%0d]: got %0d want %0d", e, cv[e*AW +: AW], 2 * e); end
    end
  endtask

  task automatic test_frame_abort();
    logic [CB-1:0] cv;
    int nd, bl, fsb, fr;
    bit to;
    drive_link(1'b0, fill_frame(8'h5A), 37);
    drive_link(1'b0, ident_frame(), FB);
    checks++; if (frame_err !== 1'b1) begin failures++;
      $display("FAIL abort_frame_err_set: got %b want 1", frame_err); end
    drive_link(1'b1, ramp_frame(), FB);
    pulse_start(1'b0, 1'b0);
    checks++; if (frame_err !== 1'b0) begin failures++;
      $display("FAIL abort_frame_err_clear: got %b want 0", frame_err); end
    collect(0, cv, nd, bl, fsb, fr, to);
    for (int e = 0; e < NN; e++) begin
      checks++;
      if (cv[e*AW +: AW] !== 18'(e)) begin failures++;
        $display("FAIL abort_c[%0d]: got %0d want %0d", e, cv[e*AW +: AW], e); end
    end
  endtask

  task automatic test_operand_order();
    logic [CB-1:0] cv;
    int nd, bl, fsb, fr;
    bit to;
    pulse_start(1'b0, 1'b0);
    drive_link(1'b1, ramp_frame(), FB);
    checks++; if ({busy, c_c, c_f, done} !== 4'b1000) begin failures++;
      $display("FAIL order_wait_hold: got %b want 1000", {busy, c_c, c_f, done}); end
    drive_link(1'b0, ident_frame(), FB);
    collect(0, cv, nd, bl, fsb, fr, to);
    // last A strobe: 2 sync + 3 to valid + 1 WAIT exit + 64 MACs + 2 to first rise,
    // minus the 4 cycles drive_link spends after raising the last serial clock
    checks++; if (fr < 67 || fr > 69) begin failures++;
      $display("FAIL order_latency: got %0d want 68", fr); end
    for (int e = 0; e < NN; e++) begin
      checks++;
      if (cv[e*AW +: AW] !== 18'(e)) begin failures++;
        $display("FAIL order_c[%0d]: got %0d want %0d", e, cv[e*AW +: AW], e); end
    end
  endtask

  task automatic test_reset_mid_send();
    logic [CB-1:0] cv;
    int nd, bl, fsb, fr;
    bit to;
    drive_link(1'b0, ident_frame(), FB);
    drive_link(1'b1, fill_frame(8'h33), FB);
    pulse_start(1'b0, 1'b0);
    collect(100, cv, nd, bl, fsb, fr, to);
    checks++; if (to) begin failures++; $display("FAIL midsend_reach_bit100: got timeout want bit 100"); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++; if ({c_d, c_c, c_f, busy, done} !== 5'b00000) begin failures++;
      $display("FAIL midsend_reset_outputs: got %b want 00000", {c_d, c_c, c_f, busy, done}); end
    rst = 1'b0;
    @(negedge clk);
    run_mm(ident_frame(), ramp_frame(), 1'b0, 1'b0, cv, nd, bl, fsb, to);
    for (int e = 0; e < NN; e++) begin
      checks++;
      if (cv[e*AW +: AW] !== 18'(e)) begin failures++;
        $display("FAIL midsend_rerun_c[%0d]: got %0d want %0d", e, cv[e*AW +: AW], e); end
    end
    checks++; if (nd != 1) begin failures++; $display("FAIL midsend_rerun_done: got %0d want 1", nd); end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; signed_mode = 1'b0; accum = 1'b0;
    a_d = 1'b0; a_c = 1'b0; a_f = 1'b0;
    b_d = 1'b0; b_c = 1'b0; b_f = 1'b0;
    test_reset();
    test_unsigned();
    test_signed();
    test_accum();
    test_frame_abort();
    test_operand_order();
    test_reset_mid_send();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
